// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receive types and constants.
// Contents: receiver state enum, error-code bit indices, default inter-edge timeout.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} ps2_rx_state_t;
  localparam int ERR_PARITY = 0;
  localparam int ERR_STOP = 1;
  localparam int PS2_TIMEOUT_DEFAULT = 100000;
endpackage

// File: rtl/ps2_mouse_receiver_if.sv
// ps2_mouse_receiver_if: PS/2 line inputs, read gate and received-byte outputs.
// master: drives the PS/2 lines and READ_ENABLE, observes the byte outputs.
// slave:  the receiver; samples the lines, drives BYTE_READY/BYTE_READ/BYTE_ERROR_CODE.
interface ps2_mouse_receiver_if;
  logic       CLK_MOUSE_IN;
  logic       DATA_MOUSE_IN;
  logic       READ_ENABLE;
  logic       BYTE_READY;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  modport master (output CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
                  input BYTE_READY, BYTE_READ, BYTE_ERROR_CODE);
  modport slave (input CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
                 output BYTE_READY, BYTE_READ, BYTE_ERROR_CODE);
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronises PS/2 clock and data lines and strobes on clock falling edges.
// Ports: CLK, RESET (async, active-low), ps2_clk/ps2_data (raw lines),
//        fall (one-CLK falling-edge strobe), data (synchronised data, aligned with fall).
module ps2_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data
);
  logic [STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic clk_prev_q, clk_prev_d, dat_prev_q, dat_prev_d, fall_q, fall_d;
  always_comb begin
    clk_sync_d = (clk_sync_q << 1) | STAGES'(ps2_clk);
    dat_sync_d = (dat_sync_q << 1) | STAGES'(ps2_data);
    clk_prev_d = clk_sync_q[STAGES-1];
    dat_prev_d = dat_sync_q[STAGES-1];
    fall_d     = clk_prev_q & ~clk_sync_q[STAGES-1];
  end
  // The data line gets the same extra stage as the clock so data matches the strobe cycle.
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      dat_prev_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      dat_prev_q <= dat_prev_d;
      fall_q     <= fall_d;
    end
  assign fall = fall_q;
  assign data = dat_prev_q;
endmodule

// File: rtl/ps2_mouse_receiver.sv
// ps2_mouse_receiver: deserialises 11-bit PS/2 device-to-host frames into bytes.
// Ports: CLK, RESET (async, active-low), bus (slave): CLK_MOUSE_IN, DATA_MOUSE_IN,
//        READ_ENABLE in; BYTE_READY pulse, BYTE_READ byte, BYTE_ERROR_CODE {stop, parity} out.
module ps2_mouse_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input logic CLK,
  input logic RESET,
  ps2_mouse_receiver_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  logic strobe, data, abort;
  ps2_rx_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, byte_q, byte_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0] err_q, err_d;
  logic par_q, par_d, ready_q, ready_d;
  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK(CLK), .RESET(RESET), .ps2_clk(bus.CLK_MOUSE_IN), .ps2_data(bus.DATA_MOUSE_IN),
    .fall(strobe), .data(data)
  );
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    err_d     = err_q;
    par_d     = par_q;
    ready_d   = state_q == DONE;
    tmo_d     = (strobe || state_q == IDLE || state_q == DONE) ? '0 : (tmo_q == TMAX ? tmo_q : tmo_q + 1'b1);
    // A strobe landing on the terminal count still counts as a valid bit.
    abort = state_q != DONE && (!bus.READ_ENABLE || (state_q != IDLE && !strobe && tmo_q == TMAX));
    if (abort) state_d = IDLE;
    else if (strobe || state_q == DONE)
      case (state_q)
        IDLE: if (!data) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
        end
        DATA: begin
          shift_d   = {data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = bit_cnt_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = data;
          state_d = STOP;
        end
        STOP: begin
          byte_d            = shift_q;
          err_d[ERR_PARITY] = ~(^shift_q ^ par_q);
          err_d[ERR_STOP]   = ~data;
          state_d           = DONE;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      byte_q    <= 8'h00;
      err_q     <= 2'b00;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      err_q     <= err_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      ready_q   <= ready_d;
    end
  assign bus.BYTE_READY      = ready_q;
  assign bus.BYTE_READ       = byte_q;
  assign bus.BYTE_ERROR_CODE = err_q;
endmodule

// File: doc/ps2_mouse_receiver.md
Name: ps2_mouse_receiver

Overview:
- Host-side PS/2 receive stage; the counterpart of the mouse transmitter on the shared CLK/DATA lines.
- Deserialises 11-bit device-to-host frames: start bit, 8 data bits LSB first, odd parity, stop bit.
- Presents each byte to the mouse master state machine with a one-cycle ready pulse and an error code.
- Gated by READ_ENABLE so it ignores the bus while the transmitter owns it.

Parameters:
- TIMEOUT_CYCLES, 100000, CLK cycles allowed between consecutive PS/2 falling edges inside a frame (2 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on CLK_MOUSE_IN and DATA_MOUSE_IN.

Ports:
- CLK  input  1  system clock, 50 MHz
- RESET  input  1  asynchronous, active-low reset
- CLK_MOUSE_IN  input  1  PS/2 clock line, sampled value
- DATA_MOUSE_IN  input  1  PS/2 data line, sampled value
- READ_ENABLE  input  1  1 = receiver may accept frames; 0 = forced idle
- BYTE_READY  output  1  one-CLK pulse: new byte valid
- BYTE_READ  output  8  last received data byte
- BYTE_ERROR_CODE  output  2  bit0 = parity error, bit1 = stop-bit error

Behaviour:
- Reset is asynchronous, active-low, on RESET; clock is CLK.
- Reset values: BYTE_READY=0, BYTE_READ=8'h00, BYTE_ERROR_CODE=2'b00, state IDLE, counters 0, synchroniser flops 1.
- Sync and edge detect:
  - Both lines pass through SYNC_STAGES flops.
  - One extra register on the clock line forms a falling-edge strobe (prev=1, cur=0), one CLK wide.
  - Data is sampled from the synchronised DATA in the same cycle as the strobe.
- Pin-to-strobe latency: SYNC_STAGES+1 CLK.
- States: IDLE, DATA, PARITY, STOP, DONE.
  - IDLE: on strobe with READ_ENABLE=1 and data=0 -> DATA, bit_cnt=0, shift register cleared.
  - IDLE: strobe with data=1 is treated as a glitch; stay IDLE.
  - DATA: each strobe shifts data into bit 7 (shift right), bit_cnt+1. Strobe at bit_cnt=7 -> PARITY.
  - PARITY: strobe captures parity bit -> STOP.
  - STOP: strobe captures stop bit; registers BYTE_READ and BYTE_ERROR_CODE -> DONE.
  - DONE: BYTE_READY=1 for exactly this cycle -> IDLE unconditionally.
- Latency: BYTE_READY asserts 2 CLK after the stop-bit strobe, i.e. SYNC_STAGES+3 CLK after the pin edge.
- Error code:
  - bit0 set when XOR(data, parity) = 0 (odd-parity violation).
  - bit1 set when stop bit = 0.
  - Both may be set together.
  - The byte is always delivered; the consumer decides whether to discard it.
- BYTE_READ and BYTE_ERROR_CODE hold until the next DONE. They are never changed by an aborted frame.
- Timeout:
  - Counter runs in DATA, PARITY and STOP.
  - Cleared on every strobe and in IDLE/DONE.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, no BYTE_READY, outputs unchanged.
  - Counter width is ceil(log2(TIMEOUT_CYCLES)); it saturates and never wraps.
- READ_ENABLE=0 in any state other than DONE -> IDLE next cycle, frame discarded. DONE always completes its pulse.
- Strobe coinciding with a timeout terminal count: the strobe wins (counter clears, bit accepted).
- Bus rate: no assumption beyond edges ≥ 3 CLK apart. 10–16.7 kHz PS/2 clocks are nominal.
- Reset mid-frame: immediate return to reset values; the next complete frame is received normally.

Decomposition:
- Package ps2_pkg:
  - state enum ps2_rx_state_t;
  - error-bit index constants ERR_PARITY=0, ERR_STOP=1;
  - default timeout constant.
- Sub-module ps2_sync_edge: parameterised synchroniser plus falling-edge strobe. Reusable by the transmitter for its edge detect.

Test Plan:
- Frame 0xFA (parity 1, stop 1) at 10 kHz, READ_ENABLE=1 -> one BYTE_READY pulse, BYTE_READ=0xFA, BYTE_ERROR_CODE=00, pulse 5 CLK after stop-bit pin edge.
- Frame 0x01 with parity=1 (wrong; correct is 0) -> BYTE_READY pulse, BYTE_READ=0x01, BYTE_ERROR_CODE=01.
- Frame 0x3C, parity 1, stop bit 0 -> BYTE_READ=0x3C, BYTE_ERROR_CODE=10. Then frame 0x3C with parity 0 and stop 0 -> BYTE_ERROR_CODE=11.
- Timeout recovery:
  - Start bit plus 4 data bits, then clock idle 2.5 ms -> no BYTE_READY, BYTE_READ unchanged.
  - Then full frame 0xAA -> exactly one pulse, BYTE_READ=0xAA, code 00.
- READ_ENABLE gating:
  - READ_ENABLE=0 for a full 0x55 frame -> no pulse.
  - READ_ENABLE dropped after bit 3 of a 0x55 frame, then restored -> no pulse; next frame 0x08 received with code 00.
- RESET pulsed low after 6 data bits of 0xF4 -> all outputs 0 within the reset; next frame 0x08 -> BYTE_READ=0x08, code 00.
